// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes and op-class helpers for the multiply/divide unit
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    // Multiply class: result lands after MULT_CYCLES
    function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    // Divide class: result lands after DIV_CYCLES
    function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - execute-stage request/result bundle for the multiply/divide unit
interface mdu_if #(
    parameter int WIDTH = 32
);
    import mdu_pkg::*;

    logic                Start;
    logic [MDU_OP_W-1:0] MDUOp;
    logic [WIDTH-1:0]    A;
    logic [WIDTH-1:0]    B;
    logic                Busy;
    logic [WIDTH-1:0]    HI;
    logic [WIDTH-1:0]    LO;

    modport master (output Start, MDUOp, A, B, input Busy, HI, LO);
    modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO);

endinterface

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational multiply/divide producing the {HI,LO} result
module mdu_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [MDU_OP_W-1:0] op,
    output logic [2*WIDTH-1:0]  result,
    output logic                div_by_zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic                      b_zero;
    logic                      ovf;
    logic        [WIDTH-1:0]   b_safe;
    logic signed [WIDTH-1:0]   sq;
    logic signed [WIDTH-1:0]   sr;
    logic        [WIDTH-1:0]   quo_s;
    logic        [WIDTH-1:0]   rem_s;
    logic        [WIDTH-1:0]   quo_u;
    logic        [WIDTH-1:0]   rem_u;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // A zero divisor is replaced by one so the dividers never see x; the
    // top level discards the result anyway via div_by_zero.
    assign b_zero = (b == '0);
    assign b_safe = b_zero ? ONE : b;

    // most-negative / -1 overflows the quotient; pin it to the wrapped value
    assign ovf   = (a == MOST_NEG) && (b == '1);
    assign sq    = $signed(a) / $signed(b_safe);
    assign sr    = $signed(a) % $signed(b_safe);
    assign quo_s = ovf ? MOST_NEG : sq;
    assign rem_s = ovf ? '0 : sr;
    assign quo_u = a / b_safe;
    assign rem_u = a % b_safe;

    // Select the result layout {HI, LO} for the requested operation
    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV: begin
                result      = {rem_s, quo_s};
                div_by_zero = b_zero;
            end
            MDU_DIVU: begin
                result      = {rem_u, quo_u};
                div_by_zero = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO registers and Busy
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [2*WIDTH-1:0] core_result;
    logic               core_dbz;
    logic               busy;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] pending;
    logic               pend_keep;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               accept;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .a           (bus.A),
        .b           (bus.B),
        .op          (bus.MDUOp),
        .result      (core_result),
        .div_by_zero (core_dbz)
    );

    // Anything arriving while busy, including MTHI/MTLO, is dropped
    assign accept = bus.Start && !busy;

    // Accept new ops, count down the iterative latency, commit HI/LO at the end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            count     <= '0;
            pending   <= '0;
            pend_keep <= 1'b0;
        end else if (accept) begin
            if (bus.MDUOp == MDU_MTHI) begin
                hi <= bus.A;
            end else if (bus.MDUOp == MDU_MTLO) begin
                lo <= bus.A;
            end else if (is_mul_op(bus.MDUOp)) begin
                pending   <= core_result;
                pend_keep <= 1'b0;
                busy      <= 1'b1;
                count     <= CW'(MULT_CYCLES);
            end else if (is_div_op(bus.MDUOp)) begin
                pending   <= core_result;
                pend_keep <= core_dbz;
                busy      <= 1'b1;
                count     <= CW'(DIV_CYCLES);
            end
        end else if (busy) begin
            if (count == CW'(1)) begin
                // divide by zero runs the full latency but leaves HI/LO alone
                if (!pend_keep) begin
                    {hi, lo} <= pending;
                end
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

    assign bus.Busy = busy;
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule
